// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx -- SD CMD-line controller.
// Serializes one 48-bit command frame ({0,1,IDX,ARG,CRC7,1}) onto the CMD pad,
// optionally receives a 48-bit response (R1/R3/R7), then holds CMD released
// for NCC ticks before returning to idle. All bit activity is paced by TICK.
//
// Ports:
//   CLK, RST (async, active-high)   clock / reset
//   TICK                            one SD bit per strobe
//   REQ, IDX, ARG, RSP_EXP          command request (level); RSP_EXP sampled on accept
//   ACK, BUSY, DONE                 accept pulse, busy level, completion pulse
//   CMD_O, CMD_OE, CMD_I            CMD pad out / enable / synchronized in
//   RSP_IDX, RSP_ARG                received response index / payload
//   ERR_TO, ERR_CRC, ERR_END        response timeout / CRC mismatch / bad end bit
//
// Build option: define SD_CMD_RSP_CRC_EN to check the response CRC (ERR_CRC);
// otherwise ERR_CRC is tied 0 and the CRC generator is idle during receive.

// CRC7 generator (x^7 + x^3 + 1). EN shifts IN into the CRC; SH shifts the
// register left, injecting 1s, so CRC[6] walks out the checksum then the end bit.
module sd_crc7 (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       SH,
   input  logic       IN,
   output logic [6:0] CRC
);
   logic [6:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = IN ^ crc_q[6];
      crc_d = crc_q;
      if (SH)
         crc_d = {crc_q[5:0], 1'b1};
      else if (EN)
         crc_d = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) crc_q <= '0;
      else     crc_q <= crc_d;
   end

   assign CRC = crc_q;
endmodule

module sd_cmd_tx #(
   parameter int unsigned NCC         = 8,
   parameter int unsigned RSP_TIMEOUT = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        TICK,
   input  logic        REQ,
   input  logic [5:0]  IDX,
   input  logic [31:0] ARG,
   input  logic        RSP_EXP,
   output logic        ACK,
   output logic        BUSY,
   output logic        CMD_O,
   output logic        CMD_OE,
   input  logic        CMD_I,
   output logic        DONE,
   output logic [5:0]  RSP_IDX,
   output logic [31:0] RSP_ARG,
   output logic        ERR_TO,
   output logic        ERR_CRC,
   output logic        ERR_END
);
   localparam int unsigned     TW       = $clog2(RSP_TIMEOUT + 1);
   localparam logic [5:0]      NCC_LAST = 6'(NCC - 1);
   localparam logic [TW-1:0]   TO_LAST  = TW'(RSP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_DATA, S_TX_CRC, S_TX_END, S_TX_REL, S_RX_WAIT, S_RX, S_NCC
   } state_t;

   state_t        state_q, state_d;
   logic [39:0]   sr_q, sr_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          rsp_exp_q, rsp_exp_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic          cmd_o_q, cmd_o_d;
   logic          cmd_oe_q, cmd_oe_d;
   logic          done_q, done_d;
   logic [5:0]    rsp_idx_q, rsp_idx_d;
   logic [31:0]   rsp_arg_q, rsp_arg_d;
   logic          err_to_q, err_to_d;
   logic          err_end_q, err_end_d;
   logic          crc_clr_q, crc_clr_d;
`ifdef SD_CMD_RSP_CRC_EN
   logic          err_crc_q, err_crc_d;
`endif

   logic          crc_en, crc_sh, crc_in;
   logic [6:0]    crc;
   logic [5:0]    rx_bit;

   sd_crc7 u_crc7 (
      .CLK (CLK),
      .RST (RST | crc_clr_q),
      .EN  (crc_en & TICK),
      .SH  (crc_sh & TICK),
      .IN  (crc_in),
      .CRC (crc)
   );

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      to_cnt_d  = to_cnt_q;
      rsp_exp_d = rsp_exp_q;
      ack_d     = 1'b0;
      busy_d    = busy_q;
      cmd_o_d   = cmd_o_q;
      cmd_oe_d  = cmd_oe_q;
      done_d    = 1'b0;
      rsp_idx_d = rsp_idx_q;
      rsp_arg_d = rsp_arg_q;
      err_to_d  = err_to_q;
      err_end_d = err_end_q;
      crc_clr_d = 1'b0;
`ifdef SD_CMD_RSP_CRC_EN
      err_crc_d = err_crc_q;
`endif
      crc_en    = 1'b0;
      crc_sh    = 1'b0;
      crc_in    = sr_q[39];
      // response bit number (46 down to 0) for the bit arriving this tick
      rx_bit    = 6'd46 - cnt_q;

      case (state_q)
         S_IDLE: if (REQ) begin
            ack_d     = 1'b1;
            busy_d    = 1'b1;
            sr_d      = {2'b01, IDX, ARG};
            rsp_exp_d = RSP_EXP;
            crc_clr_d = 1'b1;
            err_to_d  = 1'b0;
            err_end_d = 1'b0;
`ifdef SD_CMD_RSP_CRC_EN
            err_crc_d = 1'b0;
`endif
            cnt_d     = '0;
            state_d   = S_TX_DATA;
         end
         S_TX_DATA: if (TICK) begin
            cmd_oe_d = 1'b1;
            cmd_o_d  = sr_q[39];
            crc_en   = 1'b1;
            sr_d     = {sr_q[38:0], 1'b0};
            if (cnt_q == 6'd39) begin
               cnt_d   = '0;
               state_d = S_TX_CRC;
            end else
               cnt_d = cnt_q + 6'd1;
         end
         S_TX_CRC: if (TICK) begin
            cmd_o_d = crc[6];
            crc_sh  = 1'b1;
            if (cnt_q == 6'd6) begin
               cnt_d   = '0;
               state_d = S_TX_END;
            end else
               cnt_d = cnt_q + 6'd1;
         end
         // CRC[6] now holds the 1 injected by the first SH shift: the end bit
         S_TX_END: if (TICK) begin
            cmd_o_d = crc[6];
            state_d = S_TX_REL;
         end
         S_TX_REL: if (TICK) begin
            cmd_oe_d  = 1'b0;
            cmd_o_d   = 1'b1;
            crc_clr_d = 1'b1;
            cnt_d     = '0;
            to_cnt_d  = '0;
            state_d   = rsp_exp_q ? S_RX_WAIT : S_NCC;
         end
         S_RX_WAIT: begin
            crc_in = CMD_I;
            if (TICK) begin
               // a start bit on the expiry tick still wins over the timeout
               if (!CMD_I) begin
`ifdef SD_CMD_RSP_CRC_EN
                  crc_en = 1'b1;
`endif
                  cnt_d   = '0;
                  state_d = S_RX;
               end else if (to_cnt_q == TO_LAST) begin
                  err_to_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_NCC;
               end else
                  to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_RX: begin
            crc_in = CMD_I;
            if (TICK) begin
               if (rx_bit >= 6'd40 && rx_bit <= 6'd45)
                  rsp_idx_d = {rsp_idx_q[4:0], CMD_I};
               if (rx_bit >= 6'd8 && rx_bit <= 6'd39)
                  rsp_arg_d = {rsp_arg_q[30:0], CMD_I};
`ifdef SD_CMD_RSP_CRC_EN
               if (rx_bit >= 6'd8)
                  crc_en = 1'b1;
               // shift the computed CRC out bit by bit against the received field
               if (rx_bit >= 6'd1 && rx_bit <= 6'd7) begin
                  crc_sh = 1'b1;
                  if (CMD_I != crc[6])
                     err_crc_d = 1'b1;
               end
`endif
               if (rx_bit == 6'd0) begin
                  err_end_d = ~CMD_I;
                  cnt_d     = '0;
                  state_d   = S_NCC;
               end else
                  cnt_d = cnt_q + 6'd1;
            end
         end
         S_NCC: if (TICK) begin
            if (cnt_q == NCC_LAST) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else
               cnt_d = cnt_q + 6'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         to_cnt_q  <= '0;
         rsp_exp_q <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         cmd_o_q   <= 1'b1;
         cmd_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         rsp_idx_q <= '0;
         rsp_arg_q <= '0;
         err_to_q  <= 1'b0;
         err_end_q <= 1'b0;
         crc_clr_q <= 1'b0;
`ifdef SD_CMD_RSP_CRC_EN
         err_crc_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         to_cnt_q  <= to_cnt_d;
         rsp_exp_q <= rsp_exp_d;
         ack_q     <= ack_d;
         busy_q    <= busy_d;
         cmd_o_q   <= cmd_o_d;
         cmd_oe_q  <= cmd_oe_d;
         done_q    <= done_d;
         rsp_idx_q <= rsp_idx_d;
         rsp_arg_q <= rsp_arg_d;
         err_to_q  <= err_to_d;
         err_end_q <= err_end_d;
         crc_clr_q <= crc_clr_d;
`ifdef SD_CMD_RSP_CRC_EN
         err_crc_q <= err_crc_d;
`endif
      end
   end

   assign ACK     = ack_q;
   assign BUSY    = busy_q;
   assign CMD_O   = cmd_o_q;
   assign CMD_OE  = cmd_oe_q;
   assign DONE    = done_q;
   assign RSP_IDX = rsp_idx_q;
   assign RSP_ARG = rsp_arg_q;
   assign ERR_TO  = err_to_q;
   assign ERR_END = err_end_q;
`ifdef SD_CMD_RSP_CRC_EN
   assign ERR_CRC = err_crc_q;
`else
   assign ERR_CRC = 1'b0;
`endif
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx (NCC=8, RSP_TIMEOUT=16).
module tb_sd_cmd_tx;
   localparam int NCC_T = 8;
   localparam int TO_T  = 16;
`ifdef SD_CMD_RSP_CRC_EN
   localparam logic CRC_ON = 1'b1;
`else
   localparam logic CRC_ON = 1'b0;
`endif

   logic        CLK, RST, TICK, REQ, RSP_EXP, CMD_I;
   logic [5:0]  IDX;
   logic [31:0] ARG;
   logic        ACK, BUSY, CMD_O, CMD_OE, DONE, ERR_TO, ERR_CRC, ERR_END;
   logic [5:0]  RSP_IDX;
   logic [31:0] RSP_ARG;

   int n_vec = 0;
   int n_err = 0;
   int ack_cnt = 0;
   int done_cnt = 0;

   sd_cmd_tx #(.NCC(NCC_T), .RSP_TIMEOUT(TO_T)) dut (
      .CLK(CLK), .RST(RST), .TICK(TICK), .REQ(REQ), .IDX(IDX), .ARG(ARG),
      .RSP_EXP(RSP_EXP), .ACK(ACK), .BUSY(BUSY), .CMD_O(CMD_O), .CMD_OE(CMD_OE),
      .CMD_I(CMD_I), .DONE(DONE), .RSP_IDX(RSP_IDX), .RSP_ARG(RSP_ARG),
      .ERR_TO(ERR_TO), .ERR_CRC(ERR_CRC), .ERR_END(ERR_END)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (ACK === 1'b1)  ack_cnt++;
      if (DONE === 1'b1) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // one TICK consumed on a posedge; outputs sampled on the following negedge
   task automatic do_tick();
      @(negedge CLK); TICK = 1'b1;
      @(negedge CLK); TICK = 1'b0;
   endtask

   // accept + 48 transmit ticks; optionally raise REQ mid-frame
   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rsp,
                           input logic tick_on_accept, input logic req_busy,
                           output logic [47:0] frame, output int oe_bad);
      @(negedge CLK);
      REQ = 1'b1; IDX = idx; ARG = arg; RSP_EXP = rsp; TICK = tick_on_accept;
      @(negedge CLK);
      chk("ack", ACK, 1'b1);
      chk("busy_accept", BUSY, 1'b1);
      REQ = 1'b0; TICK = 1'b0;
      frame = '0; oe_bad = 0;
      for (int i = 1; i <= 48; i++) begin
         if (req_busy && i == 10) REQ = 1'b1;
         if (i == 14) REQ = 1'b0;
         do_tick();
         frame = {frame[46:0], CMD_O};
         if (CMD_OE !== 1'b1) oe_bad++;
      end
   endtask

   task automatic release_tick();
      do_tick();
      chk("oe_release", CMD_OE, 1'b0);
      chk("o_release", CMD_O, 1'b1);
   endtask

   task automatic send_rsp(input logic [47:0] rsp, input int pre);
      for (int i = 0; i < pre; i++) begin CMD_I = 1'b1; do_tick(); end
      for (int i = 47; i >= 0; i--) begin CMD_I = rsp[i]; do_tick(); end
      CMD_I = 1'b1;
   endtask

   // bounded wait for DONE; returns the NCC tick it appeared on (0 = never)
   task automatic finish_ncc(output int done_at);
      done_at = 0;
      for (int k = 1; k <= NCC_T + 4; k++) begin
         do_tick();
         if (DONE === 1'b1 && done_at == 0) begin
            done_at = k;
            chk("busy_done", BUSY, 1'b0);
         end
      end
   endtask

   logic [47:0] fr;
   int ob, da, dsnap;

   initial begin
      RST = 1'b1; TICK = 0; REQ = 0; IDX = '0; ARG = '0; RSP_EXP = 0; CMD_I = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_cmd_o", CMD_O, 1'b1);
      chk("rst_cmd_oe", CMD_OE, 1'b0);
      chk("rst_ack", ACK, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_rsp", {RSP_IDX, RSP_ARG}, 38'h0);
      chk("rst_err", {ERR_TO, ERR_CRC, ERR_END}, 3'b000);
      RST = 1'b0;

      // CMD0, no response
      send_cmd(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, fr, ob);
      chk("cmd0_frame", fr, 48'h40_00000000_95);
      chk("cmd0_oe", ob, 0);
      release_tick();
      finish_ncc(da);
      chk("cmd0_done_tick", da, NCC_T);

      // CMD8 with TICK coincident with accept (must not be consumed)
      send_cmd(6'd8, 32'h000001AA, 1'b0, 1'b1, 1'b0, fr, ob);
      chk("cmd8_frame", fr, 48'h48_000001AA_87);
      chk("cmd8_oe", ob, 0);
      release_tick();
      finish_ncc(da);
      chk("cmd8_done_tick", da, NCC_T);

      // CMD17 with REQ raised while busy
      send_cmd(6'd17, 32'h0, 1'b0, 1'b0, 1'b1, fr, ob);
      chk("cmd17_frame", fr, 48'h51_00000000_55);
      release_tick();
      finish_ncc(da);
      chk("cmd17_done_tick", da, NCC_T);
      chk("ack_count_busy", ack_cnt, 3);

      // good response after 4 idle ticks
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      release_tick();
      send_rsp(48'h00_00000000_01, 4);
      finish_ncc(da);
      chk("rsp_ok_done", da, NCC_T);
      chk("rsp_ok_idx", RSP_IDX, 6'd0);
      chk("rsp_ok_arg", RSP_ARG, 32'h0);
      chk("rsp_ok_err", {ERR_TO, ERR_CRC, ERR_END}, 3'b000);

      // one ARG bit flipped
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      release_tick();
      send_rsp(48'h00_00000001_01, 4);
      finish_ncc(da);
      chk("rsp_flip_arg", RSP_ARG, 32'h1);
      chk("rsp_flip_crc", ERR_CRC, CRC_ON);
      chk("rsp_flip_end", ERR_END, 1'b0);

      // end bit 0
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      chk("accept_clears_crc", ERR_CRC, 1'b0);
      release_tick();
      send_rsp(48'h00_00000000_00, 4);
      finish_ncc(da);
      chk("rsp_end_err", {ERR_TO, ERR_CRC, ERR_END}, 3'b001);

      // nonzero index/payload capture
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      chk("accept_clears_end", ERR_END, 1'b0);
      release_tick();
      send_rsp(48'h08_000001AA_01, 4);
      finish_ncc(da);
      chk("rsp_echo_idx", RSP_IDX, 6'd8);
      chk("rsp_echo_arg", RSP_ARG, 32'h000001AA);
      chk("rsp_echo_end", ERR_END, 1'b0);

      // timeout: CMD_I held high
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      release_tick();
      CMD_I = 1'b1;
      for (int i = 1; i < TO_T; i++) do_tick();
      chk("to_not_yet", ERR_TO, 1'b0);
      do_tick();
      chk("to_set", ERR_TO, 1'b1);
      finish_ncc(da);
      chk("to_done_tick", da, NCC_T);

      // start bit on the expiry tick wins
      send_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b0, fr, ob);
      chk("accept_clears_to", ERR_TO, 1'b0);
      release_tick();
      send_rsp(48'h00_00000000_01, TO_T - 1);
      finish_ncc(da);
      chk("edge_done", da, NCC_T);
      chk("edge_err", {ERR_TO, ERR_CRC, ERR_END}, 3'b000);

      // reset mid-frame at tick 20
      dsnap = done_cnt;
      @(negedge CLK);
      REQ = 1'b1; IDX = 6'd0; ARG = 32'h0; RSP_EXP = 1'b0;
      @(negedge CLK); REQ = 1'b0;
      for (int i = 0; i < 20; i++) do_tick();
      @(negedge CLK); RST = 1'b1;
      #1;
      chk("abort_pads", {CMD_OE, CMD_O}, 2'b01);
      chk("abort_busy", BUSY, 1'b0);
      @(negedge CLK); RST = 1'b0;
      for (int i = 0; i < 60; i++) do_tick();
      chk("abort_no_done", done_cnt, dsnap);

      send_cmd(6'd0, 32'h0, 1'b0, 1'b0, 1'b0, fr, ob);
      chk("post_rst_frame", fr, 48'h40_00000000_95);
      release_tick();
      finish_ncc(da);
      chk("post_rst_done", da, NCC_T);
      chk("ack_total", ack_cnt, 11);
      chk("done_total", done_cnt, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
